// File: rtl/aes_v2_issue.sv
// Issue/retire stage in front of the 4-cycle aes_v2 unit: holds operands for the
// unit, pulses its start, buffers the result for writeback, and drains flushed ops.
module aes_v2_issue #(
  parameter int RD_W       = 5,
  parameter bit DECRYPT_EN = 1'b1
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [31:0]     s_rs1,
  input  logic [31:0]     s_rs2,
  input  logic            s_sub,
  input  logic            s_enc,
  input  logic [RD_W-1:0] s_rd_idx,
  input  logic            flush,
  output logic            aes_valid,
  output logic [31:0]     aes_rs1,
  output logic [31:0]     aes_rs2,
  output logic            aes_sub,
  output logic            aes_enc,
  input  logic            aes_ready,
  input  logic [31:0]     aes_rd,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [31:0]     m_result,
  output logic [RD_W-1:0] m_rd_idx,
  output logic            m_illegal
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE,
    ST_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_rs1;
  logic [31:0]     r_rs2;
  logic            r_sub;
  logic            r_enc;
  logic            r_launch;
  logic [31:0]     r_result;
  logic [RD_W-1:0] r_rd_idx;
  logic            r_illegal;

  logic w_accept;
  logic w_illegal_op;
  logic w_capture;

  // A new op may enter while the buffered result retires in the same cycle.
  assign s_ready      = !flush && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && m_ready));
  assign w_accept     = s_valid && s_ready;
  assign w_illegal_op = !DECRYPT_EN && !s_enc;
  assign w_capture    = (r_state == ST_BUSY) && aes_ready && !flush;

  // NOTE: the next-state default is assigned first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = w_illegal_op ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        if (flush)          w_state_nxt = aes_ready ? ST_IDLE : ST_DRAIN;
        else if (aes_ready) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (flush)         w_state_nxt = ST_IDLE;
        else if (w_accept) w_state_nxt = w_illegal_op ? ST_DONE : ST_BUSY;
        else if (m_ready)  w_state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        // The unit cannot abort; wait for it to finish and drop its result.
        if (aes_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      // NOTE: data registers are cleared as well so the unit never sees stale operands after reset.
      r_state   <= ST_IDLE;
      r_launch  <= 1'b0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_sub     <= 1'b0;
      r_enc     <= 1'b0;
      r_result  <= '0;
      r_rd_idx  <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_launch <= w_accept && !w_illegal_op;
      if (w_accept) begin
        r_rs1     <= s_rs1;
        r_rs2     <= s_rs2;
        r_sub     <= s_sub;
        r_enc     <= s_enc;
        r_rd_idx  <= s_rd_idx;
        r_illegal <= w_illegal_op;
        if (w_illegal_op) r_result <= '0;
      end else if (w_capture) begin
        r_result <= aes_rd;
      end
    end
  end

  assign aes_valid = r_launch;
  assign aes_rs1   = r_rs1;
  assign aes_rs2   = r_rs2;
  assign aes_sub   = r_sub;
  assign aes_enc   = r_enc;
  assign m_valid   = (r_state == ST_DONE);
  assign m_result  = r_result;
  assign m_rd_idx  = r_rd_idx;
  assign m_illegal = r_illegal && m_valid;

endmodule

// File: tb/tb_aes_v2_issue.sv
// Bench for aes_v2_issue: a behavioural aes_v2 stand-in (GF(2^8) S-box / MixColumn,
// 4-cycle latency), directed protocol steps, then randomized back-to-back ops.
module tb_aes_v2_issue;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        s_valid = 1'b0, s_valid0 = 1'b0;
  logic        s_ready, s_ready0;
  logic [31:0] s_rs1 = '0, s_rs2 = '0;
  logic        s_sub = 1'b0, s_enc = 1'b0, s_enc0 = 1'b0;
  logic [4:0]  s_rd_idx = '0;
  logic        flush = 1'b0;
  logic        aes_valid, aes_sub, aes_enc, aes_ready;
  logic [31:0] aes_rs1, aes_rs2, aes_rd;
  logic        aes_valid0, aes_sub0, aes_enc0;
  logic [31:0] aes_rs10, aes_rs20;
  logic        aes_ready0 = 1'b0;
  logic [31:0] aes_rd0 = '0;
  logic        m_valid, m_illegal, m_valid0, m_illegal0;
  logic        m_ready = 1'b0;
  logic [31:0] m_result, m_result0;
  logic [4:0]  m_rd_idx, m_rd_idx0;

  int n_vec = 0;
  int n_err = 0;
  int n_av0 = 0;

  always #5 g_clk = ~g_clk;

  aes_v2_issue #(.RD_W(5), .DECRYPT_EN(1'b1)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_rs1(s_rs1), .s_rs2(s_rs2), .s_sub(s_sub), .s_enc(s_enc), .s_rd_idx(s_rd_idx),
    .flush(flush), .aes_valid(aes_valid), .aes_rs1(aes_rs1), .aes_rs2(aes_rs2),
    .aes_sub(aes_sub), .aes_enc(aes_enc), .aes_ready(aes_ready), .aes_rd(aes_rd),
    .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .m_rd_idx(m_rd_idx),
    .m_illegal(m_illegal)
  );

  aes_v2_issue #(.RD_W(5), .DECRYPT_EN(1'b0)) dut0 (
    .g_clk(g_clk), .g_reset(g_reset), .s_valid(s_valid0), .s_ready(s_ready0),
    .s_rs1(s_rs1), .s_rs2(s_rs2), .s_sub(s_sub), .s_enc(s_enc0), .s_rd_idx(s_rd_idx),
    .flush(flush), .aes_valid(aes_valid0), .aes_rs1(aes_rs10), .aes_rs2(aes_rs20),
    .aes_sub(aes_sub0), .aes_enc(aes_enc0), .aes_ready(aes_ready0), .aes_rd(aes_rd0),
    .m_valid(m_valid0), .m_ready(m_ready), .m_result(m_result0), .m_rd_idx(m_rd_idx0),
    .m_illegal(m_illegal0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- aes_v2 behavioural reference: GF(2^8) arithmetic ----
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    repeat (254) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  // Sub: bytewise (inverse) S-box of rs1. Mix: (inverse) MixColumn of {rs2[31:16], rs1[15:0]}.
  function automatic logic [31:0] aes_fn(input logic [31:0] rs1, input logic [31:0] rs2,
                                         input logic sub, input logic enc);
    logic [31:0] res = '0;
    logic [31:0] c   = {rs2[31:16], rs1[15:0]};
    logic [7:0]  cf [4];
    cf[0] = enc ? 8'h02 : 8'h0e;
    cf[1] = enc ? 8'h03 : 8'h0b;
    cf[2] = enc ? 8'h01 : 8'h0d;
    cf[3] = enc ? 8'h01 : 8'h09;
    for (int j = 0; j < 4; j++) begin
      if (sub) begin
        res[8*j +: 8] = enc ? sbox(rs1[8*j +: 8]) : inv_sbox(rs1[8*j +: 8]);
      end else begin
        for (int i = 0; i < 4; i++) res[8*j +: 8] ^= gmul(cf[(i - j + 4) % 4], c[8*i +: 8]);
      end
    end
    return res;
  endfunction

  // ---- aes_v2 stand-in: ready three cycles after start, result valid only that cycle ----
  logic [2:0]  sr = '0;
  logic [31:0] stub_res, h_rs1, h_rs2;
  logic        h_sub, h_enc;

  always @(posedge g_clk) begin
    if (g_reset) sr <= '0;
    else begin
      sr <= {sr[1:0], aes_valid};
      if (aes_valid) begin
        stub_res <= aes_fn(aes_rs1, aes_rs2, aes_sub, aes_enc);
        h_rs1 <= aes_rs1;
        h_rs2 <= aes_rs2;
        h_sub <= aes_sub;
        h_enc <= aes_enc;
      end
    end
  end

  assign aes_ready = sr[2];
  assign aes_rd    = aes_ready ? stub_res : 32'hdead_beef;

  always @(negedge g_clk) begin
    if (aes_valid0) n_av0++;
    if (!g_reset) begin
      if (aes_valid) check("aes_valid_while_busy", {29'd0, sr}, 32'd0);
      if (sr != 3'd0) begin
        check("aes_rs1_held", aes_rs1, h_rs1);
        check("aes_rs2_held", aes_rs2, h_rs2);
        check("aes_op_held", {30'd0, aes_sub, aes_enc}, {30'd0, h_sub, h_enc});
      end
    end
  end

  // ---- stimulus helpers ----
  task automatic next_cycle();
    @(posedge g_clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] rs1, input logic [31:0] rs2, input logic sub,
                       input logic enc, input logic [4:0] rd, input logic exp_mv);
    s_valid = 1'b1; s_rs1 = rs1; s_rs2 = rs2; s_sub = sub; s_enc = enc; s_rd_idx = rd;
    @(negedge g_clk);
    check("accept_s_ready", 32'(s_ready), 32'd1);
    check("accept_m_valid", 32'(m_valid), 32'(exp_mv));
    next_cycle();
    s_valid = 1'b0;
  endtask

  // Walks cycles A+1..A+5 after an accept; leaves the bench in A+6.
  task automatic walk(input logic [31:0] exp, input logic [4:0] rd, input string tag);
    for (int k = 1; k <= 5; k++) begin
      @(negedge g_clk);
      check({tag, "_aes_valid"}, 32'(aes_valid), 32'(k == 1));
      check({tag, "_m_valid"}, 32'(m_valid), 32'(k == 5));
      if (k == 5) begin
        check({tag, "_m_result"}, m_result, exp);
        check({tag, "_m_rd_idx"}, 32'(m_rd_idx), 32'(rd));
        check({tag, "_m_illegal"}, 32'(m_illegal), 32'd0);
      end
      next_cycle();
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] r1, r2, x1;
  logic        rsub, renc;
  logic [4:0]  rrd;

  initial begin
    // Reset
    repeat (3) next_cycle();
    g_reset = 1'b0;
    @(negedge g_clk);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_aes_valid", 32'(aes_valid), 32'd0);
    check("rst_m_illegal", 32'(m_illegal), 32'd0);
    check("rst_m_result", m_result, 32'd0);
    check("rst_aes_rs1", aes_rs1, 32'd0);
    next_cycle();

    // Basic ops with known answers
    m_ready = 1'b1;
    issue(32'h0, 32'h0, 1'b1, 1'b1, 5'd5, 1'b0);
    walk(32'h6363_6363, 5'd5, "enc_sub");
    @(negedge g_clk);
    check("retired_m_valid", 32'(m_valid), 32'd0);
    next_cycle();
    issue(32'h0, 32'h0, 1'b1, 1'b0, 5'd7, 1'b0);
    walk(32'h5252_5252, 5'd7, "dec_sub");
    issue(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b1, 5'd9, 1'b0);
    walk(32'h0101_0101, 5'd9, "enc_mix");

    // Decrypt rejected when DECRYPT_EN=0
    s_valid0 = 1'b1; s_enc0 = 1'b0; s_sub = 1'b1; s_rd_idx = 5'd3; s_rs1 = 32'h1234_5678;
    @(negedge g_clk);
    check("ill_s_ready", 32'(s_ready0), 32'd1);
    next_cycle();
    s_valid0 = 1'b0;
    @(negedge g_clk);
    check("ill_m_valid", 32'(m_valid0), 32'd1);
    check("ill_m_illegal", 32'(m_illegal0), 32'd1);
    check("ill_m_result", m_result0, 32'd0);
    check("ill_m_rd_idx", 32'(m_rd_idx0), 32'd3);
    next_cycle();
    @(negedge g_clk);
    check("ill_retired", 32'(m_valid0), 32'd0);
    check("ill_aes_valid_never", 32'(n_av0), 32'd0);
    next_cycle();

    // Writeback stall, then retire and accept in the same cycle
    m_ready = 1'b0;
    r1 = 32'h0011_2233;
    x1 = aes_fn(r1, 32'h4455_6677, 1'b1, 1'b1);
    issue(r1, 32'h4455_6677, 1'b1, 1'b1, 5'd12, 1'b0);
    walk(x1, 5'd12, "stall");
    s_valid = 1'b1; s_rs1 = 32'hcafe_f00d; s_rs2 = 32'h0bad_1dea; s_sub = 1'b0; s_enc = 1'b0;
    s_rd_idx = 5'd30;
    repeat (10) begin
      @(negedge g_clk);
      check("stall_m_valid", 32'(m_valid), 32'd1);
      check("stall_m_result", m_result, x1);
      check("stall_m_rd_idx", 32'(m_rd_idx), 32'd12);
      check("stall_s_ready", 32'(s_ready), 32'd0);
      next_cycle();
    end
    m_ready = 1'b1;
    issue(32'hcafe_f00d, 32'h0bad_1dea, 1'b0, 1'b0, 5'd30, 1'b1);
    walk(aes_fn(32'hcafe_f00d, 32'h0bad_1dea, 1'b0, 1'b0), 5'd30, "b2b");

    // Flush in A+2: drain until the unit finishes, then a clean op
    issue(32'h89ab_cdef, 32'h0, 1'b1, 1'b1, 5'd1, 1'b0);
    @(negedge g_clk);
    check("fl_busy_aes_valid", 32'(aes_valid), 32'd1);
    next_cycle();
    flush = 1'b1;
    @(negedge g_clk);
    check("fl_a2_s_ready", 32'(s_ready), 32'd0);
    next_cycle();
    flush = 1'b0;
    s_valid = 1'b1;
    for (int k = 3; k <= 4; k++) begin
      @(negedge g_clk);
      check("fl_drain_s_ready", 32'(s_ready), 32'd0);
      check("fl_drain_m_valid", 32'(m_valid), 32'd0);
      check("fl_drain_aes_ready", 32'(aes_ready), 32'(k == 4));
      next_cycle();
    end
    issue(32'h0f1e_2d3c, 32'h4b5a_6978, 1'b1, 1'b0, 5'd2, 1'b0);
    walk(aes_fn(32'h0f1e_2d3c, 32'h4b5a_6978, 1'b1, 1'b0), 5'd2, "after_drain");

    // Flush in IDLE blocks the request
    flush = 1'b1; s_valid = 1'b1;
    @(negedge g_clk);
    check("fl_idle_s_ready", 32'(s_ready), 32'd0);
    next_cycle();
    flush = 1'b0; s_valid = 1'b0;
    repeat (6) begin
      @(negedge g_clk);
      check("fl_idle_aes_valid", 32'(aes_valid), 32'd0);
      check("fl_idle_m_valid", 32'(m_valid), 32'd0);
      next_cycle();
    end

    // Flush in DONE drops the buffered result even with m_ready high
    m_ready = 1'b0;
    issue(32'h5555_aaaa, 32'h0, 1'b1, 1'b1, 5'd4, 1'b0);
    walk(aes_fn(32'h5555_aaaa, 32'h0, 1'b1, 1'b1), 5'd4, "fl_done");
    flush = 1'b1; m_ready = 1'b1;
    @(negedge g_clk);
    check("fl_done_s_ready", 32'(s_ready), 32'd0);
    next_cycle();
    flush = 1'b0;
    @(negedge g_clk);
    check("fl_done_m_valid", 32'(m_valid), 32'd0);
    check("fl_done_s_ready_after", 32'(s_ready), 32'd1);
    next_cycle();

    // Flush coincident with aes_ready discards the result
    issue(32'h7777_1111, 32'h0, 1'b1, 1'b1, 5'd6, 1'b0);
    repeat (3) next_cycle();
    flush = 1'b1;
    @(negedge g_clk);
    check("fl_rdy_aes_ready", 32'(aes_ready), 32'd1);
    next_cycle();
    flush = 1'b0;
    repeat (3) begin
      @(negedge g_clk);
      check("fl_rdy_m_valid", 32'(m_valid), 32'd0);
      check("fl_rdy_s_ready", 32'(s_ready), 32'd1);
      next_cycle();
    end

    // Reset mid-op in A+2
    issue(32'h1357_9bdf, 32'h2468_ace0, 1'b0, 1'b1, 5'd17, 1'b0);
    next_cycle();
    g_reset = 1'b1;
    next_cycle();
    g_reset = 1'b0;
    @(negedge g_clk);
    check("mrst_aes_valid", 32'(aes_valid), 32'd0);
    check("mrst_m_valid", 32'(m_valid), 32'd0);
    check("mrst_s_ready", 32'(s_ready), 32'd1);
    check("mrst_m_illegal", 32'(m_illegal), 32'd0);
    check("mrst_m_result", m_result, 32'd0);
    check("mrst_aes_rs1", aes_rs1, 32'd0);
    check("mrst_m_rd_idx", 32'(m_rd_idx), 32'd0);
    next_cycle();
    repeat (2) begin
      @(negedge g_clk);
      check("mrst_quiet_m_valid", 32'(m_valid), 32'd0);
      next_cycle();
    end
    issue(32'h1357_9bdf, 32'h2468_ace0, 1'b0, 1'b1, 5'd17, 1'b0);
    walk(aes_fn(32'h1357_9bdf, 32'h2468_ace0, 1'b0, 1'b1), 5'd17, "post_rst");

    // Randomized back-to-back ops with random writeback stalls
    m_ready = 1'b0;
    r1 = $urandom; r2 = $urandom; rsub = 1'($urandom); renc = 1'($urandom); rrd = 5'($urandom);
    sb.push_back('{aes_fn(r1, r2, rsub, renc), rrd});
    issue(r1, r2, rsub, renc, rrd, 1'b0);
    for (int n = 0; n < 40; n++) begin
      e = sb.pop_front();
      walk(e.res, e.rd, "rnd");
      repeat ($urandom_range(0, 3)) begin
        @(negedge g_clk);
        check("rnd_hold_m_result", m_result, e.res);
        check("rnd_hold_m_valid", 32'(m_valid), 32'd1);
        next_cycle();
      end
      m_ready = 1'b1;
      if (n < 39) begin
        r1 = $urandom; r2 = $urandom; rsub = 1'($urandom); renc = 1'($urandom); rrd = 5'($urandom);
        sb.push_back('{aes_fn(r1, r2, rsub, renc), rrd});
        issue(r1, r2, rsub, renc, rrd, 1'b1);
      end else begin
        @(negedge g_clk);
        check("rnd_last_m_valid", 32'(m_valid), 32'd1);
        next_cycle();
        @(negedge g_clk);
        check("rnd_last_retired", 32'(m_valid), 32'd0);
      end
      m_ready = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
